// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode 0 master.
package spi_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLoad,
    StCsSetup,
    StSclkLow,
    StSclkHigh,
    StPush,
    StGap,
    StCsHold,
    StCsHigh
  } spi_master_state_t;

  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  // Bit counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/spi_master_fifo_fifo.sv
// Synchronous FIFO with count-based flags; read data is either registered on pop
// or a combinational view of the head entry.
module spi_master_fifo_fifo #(
  parameter int unsigned Width     = 8,
  parameter int unsigned Depth     = 8,
  parameter bit          ShowAhead = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_en,
  input  logic [Width-1:0] write_data,
  input  logic             read_en,
  output logic [Width-1:0] read_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_write, do_read;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign do_write = write_en && !full;
  assign do_read  = read_en && !empty;

  function automatic logic [AddrW-1:0] ptr_inc(logic [AddrW-1:0] ptr);
    return (ptr == AddrW'(Depth - 1)) ? '0 : ptr + AddrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_write) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_read)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_write && !do_read) begin
        count_q <= count_q + CntW'(1);
      end else if (do_read && !do_write) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  if (ShowAhead) begin : g_show_ahead
    assign read_data = mem_q[rd_ptr_q];
  end else begin : g_registered
    logic [Width-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (do_read) begin
        rdata_q <= mem_q[rd_ptr_q];
      end
    end
    assign read_data = rdata_q;
  end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI mode 0 master: TX FIFO words shifted out MSB-first, MISO words collected into
// an RX FIFO; queued words stream back-to-back under one CS_n assertion.
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TxFIFODepth = 8,
  parameter int unsigned RxFIFODepth = 8,
  parameter int unsigned CLK_DIV     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             CS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  input  logic [WIDTH-1:0] TXdata,
  input  logic             writeEn,
  output logic             TXFIFOfull,
  output logic             TXFIFOempty,
  output logic [WIDTH-1:0] RXdata,
  input  logic             readEn,
  output logic             RXFIFOfull,
  output logic             RXFIFOempty,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned DivW = $clog2(CLK_DIV);

  spi_master_state_t state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             tx_rd_en, rx_wr_en, div_done, can_start;
  logic [WIDTH-1:0] tx_rdata;

  spi_master_fifo_fifo #(
    .Width     (WIDTH),
    .Depth     (TxFIFODepth),
    .ShowAhead (1'b0)
  ) u_tx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (writeEn),
    .write_data (TXdata),
    .read_en    (tx_rd_en),
    .read_data  (tx_rdata),
    .full       (TXFIFOfull),
    .empty      (TXFIFOempty)
  );

  spi_master_fifo_fifo #(
    .Width     (WIDTH),
    .Depth     (RxFIFODepth),
    .ShowAhead (1'b1)
  ) u_rx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (rx_wr_en),
    .write_data (rx_shift_q),
    .read_en    (readEn),
    .read_data  (RXdata),
    .full       (RXFIFOfull),
    .empty      (RXFIFOempty)
  );

  assign div_done  = (div_q == DivW'(CLK_DIV - 1));
  assign can_start = !TXFIFOempty && !RXFIFOfull;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    tx_rd_en   = 1'b0;
    rx_wr_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (can_start) begin
          tx_rd_en = 1'b1;
          state_d  = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        tx_shift_d = tx_rdata;
        bit_cnt_d  = CntW'(WIDTH);
        if (cs_n_q) begin
          cs_n_d  = 1'b0;
          div_d   = '0;
          state_d = StCsSetup;
        end else begin
          // Chained word: PUSH/GAP/FETCH/LOAD already held SCLK low, so trim this
          // phase by one to keep the inter-word low gap at CLK_DIV+3.
          div_d   = DivW'(1);
          state_d = StSclkLow;
        end
      end
      StCsSetup: begin
        if (div_done) begin
          div_d   = '0;
          state_d = StSclkLow;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StSclkLow: begin
        if (div_done) begin
          div_d      = '0;
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[WIDTH-2:0], MISO};
          state_d    = StSclkHigh;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StSclkHigh: begin
        if (div_done) begin
          div_d      = '0;
          sclk_d     = 1'b0;
          tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d  = bit_cnt_q - CntW'(1);
          state_d    = (bit_cnt_q == CntW'(1)) ? StPush : StSclkLow;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StPush: begin
        rx_wr_en = 1'b1;
        state_d  = StGap;
      end
      StGap: begin
        if (can_start) begin
          tx_rd_en = 1'b1;
          state_d  = StFetch;
        end else begin
          div_d   = '0;
          state_d = StCsHold;
        end
      end
      StCsHold: begin
        if (div_done) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          state_d = StCsHigh;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StCsHigh: begin
        if (div_done) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= CPOL;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
    end
  end

  assign CS_n = cs_n_q;
  assign SCLK = sclk_q;
  assign MOSI = tx_shift_q[WIDTH-1];
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_spi_master_fifo.sv
// Self-checking bench: SPI slave model plus queue-based expectations of TX/RX word flow
// and SCLK/CS_n timing, with directed transfers.
module tb_spi_master_fifo;

  localparam int W   = 8;
  localparam int TXD = 8;
  localparam int RXD = 2;
  localparam int DIV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n, sclk, mosi, miso;
  logic [7:0] tx_data = 8'h00;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic       tx_full, tx_empty, rx_full, rx_empty, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_master_fifo #(
    .WIDTH       (W),
    .TxFIFODepth (TXD),
    .RxFIFODepth (RXD),
    .CLK_DIV     (DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CS_n        (cs_n),
    .SCLK        (sclk),
    .MOSI        (mosi),
    .MISO        (miso),
    .TXdata      (tx_data),
    .writeEn     (write_en),
    .TXFIFOfull  (tx_full),
    .TXFIFOempty (tx_empty),
    .RXdata      (rx_data),
    .readEn      (read_en),
    .RXFIFOfull  (rx_full),
    .RXFIFOempty (rx_empty),
    .busy        (busy)
  );

  logic loopback = 1'b0;
  logic miso_q = 1'b0;
  assign miso = loopback ? mosi : miso_q;

  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic check_ge(string name, int act, int min);
    total++;
    if (act < min) begin
      bad++;
      $display("FAIL %s: got %0d want >= %0d", name, act, min);
    end
  endtask

  task automatic check_list(string name, input logic [7:0] got[$], input logic [7:0] want[$]);
    check({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++) check(name, got[i], want[i]);
  endtask

  // Model state: words the host queued, words the slave sent, bench-observed words.
  logic [7:0] exp_tx[$], exp_rx[$], slave_tx[$], got_rx[$], got_mosi[$];
  logic       p_cs = 1'b1, p_sclk = 1'b0, had_cs_rise = 1'b0;
  int         run = 0, since_cs_fall = 0, since_cs_rise = 0, since_fall = 0;
  int         bit_i = 0, rises = 0, win_cnt = 0, last_win_rises = 0;
  int         last_high = 0, last_low = 0, last_gap = 0, last_setup = 0;
  logic [7:0] s_word = 8'h00, m_word = 8'h00;
  logic       auto_drain = 1'b1, pop_req = 1'b0;

  function automatic logic peek_msb();
    return (slave_tx.size() != 0) ? slave_tx[0][7] : 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_tx.delete(); exp_rx.delete(); slave_tx.delete();
      p_cs = 1'b1; p_sclk = 1'b0; had_cs_rise = 1'b0; miso_q = 1'b0;
      run = 0; since_cs_fall = 0; since_cs_rise = 0; since_fall = 0;
      bit_i = 0; rises = 0;
    end else begin
      since_cs_fall++; since_cs_rise++; since_fall++;
      if (cs_n) begin
        check("cs_high_sclk", sclk, 1'b0);
        check("cs_high_mosi", mosi, 1'b0);
      end
      if (!busy) begin
        check("idle_cs", cs_n, 1'b1);
        check("idle_txempty", tx_empty, exp_tx.size() == 0);
        check("idle_rxempty", rx_empty, exp_rx.size() == 0);
        check("idle_rxfull", rx_full, exp_rx.size() == RXD);
      end
      if (p_cs && !cs_n) begin
        if (had_cs_rise) check_ge("cs_min_high", since_cs_rise, DIV);
        since_cs_fall = 0; rises = 0; bit_i = 0; win_cnt++;
        miso_q = peek_msb();
      end
      if (!p_cs && cs_n) begin
        check("cs_whole_words", bit_i, 0);
        check_ge("cs_hold", since_fall, DIV);
        last_win_rises = rises; had_cs_rise = 1'b1; since_cs_rise = 0;
      end
      if (!p_sclk && sclk) begin
        check("rise_cs_low", cs_n, 1'b0);
        if (rises == 0) begin
          last_setup = since_cs_fall;
          check_ge("cs_setup", since_cs_fall, DIV);
        end else if (bit_i == 0) begin
          last_gap = run;
          check("word_gap", run, DIV + 3);
        end else begin
          last_low = run;
          check("sclk_low", run, DIV);
        end
        if (bit_i == 0) s_word = (slave_tx.size() != 0) ? slave_tx.pop_front() : 8'h00;
        m_word = {m_word[6:0], mosi};
        bit_i++; rises++;
        if (bit_i == W) begin
          bit_i = 0;
          got_mosi.push_back(m_word);
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL mosi_word: got %0h want none queued", m_word);
          end else begin
            check("mosi_word", m_word, exp_tx.pop_front());
          end
          exp_rx.push_back(loopback ? m_word : s_word);
        end
      end
      if (p_sclk && !sclk) begin
        last_high = run;
        check("sclk_high", run, DIV);
        since_fall = 0;
        miso_q = (bit_i != 0) ? s_word[7 - bit_i] : peek_msb();
      end
      if (sclk == p_sclk) run++;
      else run = 1;
      if (read_en && !rx_empty) begin
        got_rx.push_back(rx_data);
        if (exp_rx.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_word: got %0h want none expected", rx_data);
        end else begin
          check("rx_word", rx_data, exp_rx.pop_front());
        end
      end
      if (write_en && !tx_full) exp_tx.push_back(tx_data);
      p_cs = cs_n; p_sclk = sclk;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_req) begin
      read_en = 1'b1;
      pop_req = 1'b0;
    end else begin
      read_en = auto_drain && !rx_empty && rst_n;
    end
  end

  task automatic push_word(input logic [7:0] w);
    @(posedge clk); #1;
    write_en = 1'b1; tx_data = w;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic run_until_quiet(string name);
    int n;
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); #1; n++; end
    if (!busy) begin
      total++; bad++;
      $display("FAIL %s_start: got busy=0 want busy=1 within 200 cycles", name);
    end
    n = 0;
    while (!(!busy && (tx_empty || rx_full) && !(auto_drain && !rx_empty)) && n < 5000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL %s_quiet: got busy=%0b want idle within 5000 cycles", name, busy);
    end
    repeat (2) begin @(negedge clk); #1; end
  endtask

  initial begin
    logic [7:0] want[$];
    int w0, n, nonempty;

    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_txempty", tx_empty, 1'b1);
    check("rst_rxempty", rx_empty, 1'b1);
    rst_n = 1'b1;

    // Single word
    got_rx.delete(); got_mosi.delete();
    slave_tx.push_back(8'h3C);
    push_word(8'hA5);
    run_until_quiet("t1");
    want = {8'hA5}; check_list("t1_mosi", got_mosi, want);
    want = {8'h3C}; check_list("t1_rx", got_rx, want);
    check("t1_rises", last_win_rises, 8);
    check("t1_cs", cs_n, 1'b1);
    check("t1_busy", busy, 1'b0);

    // Back-to-back in one CS_n window
    got_rx.delete(); got_mosi.delete();
    w0 = win_cnt;
    slave_tx.push_back(8'h11); slave_tx.push_back(8'h22); slave_tx.push_back(8'h33);
    push_word(8'h01); push_word(8'h02); push_word(8'h03);
    run_until_quiet("t2");
    check("t2_windows", win_cnt - w0, 1);
    check("t2_rises", last_win_rises, 24);
    want = {8'h01, 8'h02, 8'h03}; check_list("t2_mosi", got_mosi, want);
    want = {8'h11, 8'h22, 8'h33}; check_list("t2_rx", got_rx, want);
    check("t4_high", last_high, 3);
    check("t4_low", last_low, 3);
    check("t4_gap", last_gap, 6);
    check_ge("t4_setup", last_setup, 3);

    // RX stall with a 2-entry RX FIFO
    got_rx.delete(); got_mosi.delete();
    auto_drain = 1'b0;
    slave_tx.push_back(8'h81); slave_tx.push_back(8'h42);
    slave_tx.push_back(8'h24); slave_tx.push_back(8'h18);
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3); push_word(8'hA4);
    run_until_quiet("t3a");
    check("t3_rises_a", last_win_rises, 16);
    check("t3_rxfull_a", rx_full, 1'b1);
    check("t3_txempty_a", tx_empty, 1'b0);
    check("t3_nopop", got_rx.size(), 0);
    pop_req = 1'b1;
    run_until_quiet("t3b");
    check("t3_rises_b", last_win_rises, 8);
    check("t3_rxfull_b", rx_full, 1'b1);
    check("t3_txempty_b", tx_empty, 1'b0);
    auto_drain = 1'b1;
    run_until_quiet("t3c");
    want = {8'h81, 8'h42, 8'h24, 8'h18}; check_list("t3_rx", got_rx, want);
    want = {8'hA1, 8'hA2, 8'hA3, 8'hA4}; check_list("t3_mosi", got_mosi, want);

    // Reset after the 3rd rising edge
    got_rx.delete(); got_mosi.delete();
    slave_tx.push_back(8'h0F);
    push_word(8'hF0);
    n = 0;
    while (rises != 3 && n < 500) begin @(negedge clk); #1; n++; end
    check("t5_reached", rises, 3);
    check("t5_sclk_before", sclk, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_cs", cs_n, 1'b1);
    check("t5_sclk", sclk, 1'b0);
    check("t5_mosi", mosi, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_txempty", tx_empty, 1'b1);
    check("t5_rxempty", rx_empty, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    nonempty = 0;
    repeat (80) begin
      @(negedge clk); #1;
      if (!rx_empty || busy) nonempty++;
    end
    check("t5_no_activity", nonempty, 0);
    check("t5_no_rx", got_rx.size(), 0);

    // Loopback, then slave-preloaded reply
    got_rx.delete(); got_mosi.delete();
    loopback = 1'b1;
    push_word(8'h00); push_word(8'hFF); push_word(8'h5A);
    run_until_quiet("t6a");
    want = {8'h00, 8'hFF, 8'h5A}; check_list("t6_loop", got_rx, want);
    loopback = 1'b0;
    got_rx.delete();
    slave_tx.push_back(8'hC3);
    push_word(8'h00);
    run_until_quiet("t6b");
    want = {8'hC3}; check_list("t6_slave", got_rx, want);

    check("model_tx_drained", exp_tx.size(), 0);
    check("model_rx_drained", exp_rx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
